// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first serial unsigned magnitude comparator
// Walks 2-bit slices of the captured operands and stops at the first unequal slice.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Less,
  output logic             Greater
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic [WIDTH-1:0] ra_sh, rb_sh;
  logic [1:0]       sa, sb;

  // Slice idx sits at bit offset 2*idx; shifting keeps the select in range for any WIDTH.
  assign ra_sh = ra_q >> {idx_q, 1'b0};
  assign rb_sh = rb_q >> {idx_q, 1'b0};
  assign sa    = ra_sh[1:0];
  assign sb    = rb_sh[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IW'(N - 1);
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (sa > sb) begin
          gt_d    = 1'b1;
          state_d = S_DONE;
        end else if (sa < sb) begin
          lt_d    = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign Eq      = eq_q;
  assign Less    = lt_q;
  assign Greater = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed and random checks for serial_magnitude_comparator
// Drives a WIDTH=8 and a WIDTH=2 instance; expectations come from plain unsigned arithmetic.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, eq8, lt8, gt8;
  logic       busy2, done2, eq2, lt2, gt2;

  int checks = 0;
  int errors = 0;
  bit sel;

  serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .Eq(eq8), .Less(lt8), .Greater(gt8)
  );

  serial_magnitude_comparator #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .Eq(eq2), .Less(lt2), .Greater(gt2)
  );

  always #5 clk = ~clk;

  logic       obs_busy, obs_done;
  logic [2:0] obs_flags;
  assign obs_busy  = sel ? busy2 : busy8;
  assign obs_done  = sel ? done2 : done8;
  assign obs_flags = sel ? {eq2, lt2, gt2} : {eq8, lt8, gt8};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Slices examined: the slice holding the highest differing bit, or all of them.
  function automatic int ref_slices(input logic [7:0] x, input logic [7:0] y, input int n);
    logic [7:0] d;
    d = x ^ y;
    for (int p = 7; p >= 0; p--) begin
      if (d[p]) return n - p / 2;
    end
    return n;
  endfunction

  // Called just after a falling edge; returns just after the falling edge of the
  // first idle cycle after done.
  task automatic run_cmp(input bit use2, input logic [7:0] av, input logic [7:0] bv,
                         input bit keep);
    int         n, k;
    logic [7:0] ma, mb;
    logic [2:0] exp_flags;
    sel = use2;
    n   = use2 ? 1 : 4;
    ma  = use2 ? {6'b0, av[1:0]} : av;
    mb  = use2 ? {6'b0, bv[1:0]} : bv;
    k   = ref_slices(ma, mb, n);
    exp_flags = {ma == mb, ma < mb, ma > mb};
    if (use2) begin
      a2 = ma[1:0]; b2 = mb[1:0]; start2 = 1'b1;
    end else begin
      a8 = av; b8 = bv; start8 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (keep) begin
      a8 = 8'h00; b8 = 8'hFF;
    end else begin
      start8 = 1'b0; start2 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      a2 = 2'($urandom); b2 = 2'($urandom);
    end
    for (int c = 1; c <= k + 1; c++) begin
      if (c > 1) @(negedge clk);
      check("busy_active", {7'b0, obs_busy}, 8'h01);
      check("done_timing", {7'b0, obs_done}, {7'b0, c == k + 1});
      if (c <= k) check("flags_compare", {5'b0, obs_flags}, 8'h00);
      else        check("flags_done", {5'b0, obs_flags}, {5'b0, exp_flags});
    end
    @(negedge clk);
    check("busy_after", {7'b0, obs_busy}, 8'h00);
    check("done_after", {7'b0, obs_done}, 8'h00);
    check("flags_held", {5'b0, obs_flags}, {5'b0, exp_flags});
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", {7'b0, busy8}, 8'h00);
    check("rst_done8", {7'b0, done8}, 8'h00);
    check("rst_flags8", {5'b0, eq8, lt8, gt8}, 8'h00);
    check("rst_busy2", {7'b0, busy2}, 8'h00);
    check("rst_flags2", {5'b0, eq2, lt2, gt2}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_flags8", {5'b0, eq8, lt8, gt8}, 8'h00);

    run_cmp(1'b0, 8'hA5, 8'hA5, 1'b0);
    @(negedge clk);
    check("eq_held_later", {5'b0, eq8, lt8, gt8}, 8'h04);
    run_cmp(1'b0, 8'h80, 8'h7F, 1'b0);
    run_cmp(1'b0, 8'h12, 8'h13, 1'b0);

    // Start held through DONE must not be accepted until the following idle cycle.
    run_cmp(1'b0, 8'h40, 8'h30, 1'b1);
    run_cmp(1'b0, 8'h00, 8'hFF, 1'b0);

    a8 = 8'h55; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", {7'b0, busy8}, 8'h00);
    check("midrst_done", {7'b0, done8}, 8'h00);
    check("midrst_flags", {5'b0, eq8, lt8, gt8}, 8'h00);
    run_cmp(1'b0, 8'h01, 8'h02, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_cmp(1'b1, 8'(i / 4), 8'(i % 4), 1'b0);
    end

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run_cmp(1'b0, ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
